// File: rtl/reg_bank_mp_if.sv
// Bus bundle for reg_bank_mp: one write port, one reserve port, two read ports
// and the scoreboard status outputs.
interface reg_bank_mp_if #(
    parameter int WIDTH = 16,
    parameter int ID_W  = 3
);
    localparam int DEPTH = 2 ** ID_W;

    logic              wrEn;
    logic [ID_W-1:0]   wrId;
    logic [WIDTH-1:0]  wrData;
    logic              rsvEn;
    logic [ID_W-1:0]   rsvId;
    logic              rdEnA;
    logic [ID_W-1:0]   rdIdA;
    logic [WIDTH-1:0]  rdDataA;
    logic              rdRdyA;
    logic              rdEnB;
    logic [ID_W-1:0]   rdIdB;
    logic [WIDTH-1:0]  rdDataB;
    logic              rdRdyB;
    logic [DEPTH-1:0]  pendMask;
    logic              rsvErr;

    modport master (
        output wrEn, wrId, wrData, rsvEn, rsvId,
        output rdEnA, rdIdA, rdEnB, rdIdB,
        input  rdDataA, rdRdyA, rdDataB, rdRdyB, pendMask, rsvErr
    );

    modport slave (
        input  wrEn, wrId, wrData, rsvEn, rsvId,
        input  rdEnA, rdIdA, rdEnB, rdIdB,
        output rdDataA, rdRdyA, rdDataB, rdRdyB, pendMask, rsvErr
    );
endinterface

// File: rtl/reg_bank_mp.sv
// Multi-port register bank with a per-register pending scoreboard.
// One write port, two registered read ports with write-through bypass.
// A read reports ready only if the register is not pending after this edge's
// write and reserve, so a reserve issued alongside a read already shows up.
module reg_bank_mp #(
    parameter int WIDTH   = 16,
    parameter int ID_W    = 3,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    reg_bank_mp_if.slave  bus
);
    localparam int DEPTH = 2 ** ID_W;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_next;
    logic             wr_ok;
    logic             rsv_ok;
    logic             rsv_err_set;
    logic             rsv_err;

    logic [WIDTH-1:0] rd_data_a, rd_data_b;
    logic             rd_rdy_a, rd_rdy_b;
    logic [WIDTH-1:0] rd_data_a_nxt, rd_data_b_nxt;
    logic             rd_rdy_a_nxt, rd_rdy_b_nxt;

    // Qualify strobes (index 0 is inert when hardwired) and build next pending vector.
    always_comb begin
        wr_ok  = bus.wrEn  && !(ZERO_R0 && (bus.wrId  == '0));
        rsv_ok = bus.rsvEn && !(ZERO_R0 && (bus.rsvId == '0));
        pend_next = pend;
        if (wr_ok) begin
            pend_next[bus.wrId] = 1'b0;
        end
        // Reserve wins over a same-index write: it belongs to a newer producer.
        if (rsv_ok) begin
            pend_next[bus.rsvId] = 1'b1;
        end
        rsv_err_set = rsv_ok && pend[bus.rsvId] && !(wr_ok && (bus.wrId == bus.rsvId));
    end

    // Port A read value with write-through bypass.
    always_comb begin
        rd_data_a_nxt = '0;
        rd_rdy_a_nxt  = 1'b1;
        if (!(ZERO_R0 && (bus.rdIdA == '0))) begin
            rd_data_a_nxt = (wr_ok && (bus.wrId == bus.rdIdA)) ? bus.wrData : regs[bus.rdIdA];
            rd_rdy_a_nxt  = ~pend_next[bus.rdIdA];
        end
    end

    // Port B read value with write-through bypass.
    always_comb begin
        rd_data_b_nxt = '0;
        rd_rdy_b_nxt  = 1'b1;
        if (!(ZERO_R0 && (bus.rdIdB == '0))) begin
            rd_data_b_nxt = (wr_ok && (bus.wrId == bus.rdIdB)) ? bus.wrData : regs[bus.rdIdB];
            rd_rdy_b_nxt  = ~pend_next[bus.rdIdB];
        end
    end

    // Register file, scoreboard, read-port registers and sticky reserve error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pend      <= '0;
            rsv_err   <= 1'b0;
            rd_data_a <= '0;
            rd_rdy_a  <= 1'b1;
            rd_data_b <= '0;
            rd_rdy_b  <= 1'b1;
        end else begin
            if (wr_ok) begin
                regs[bus.wrId] <= bus.wrData;
            end
            pend <= pend_next;
            if (rsv_err_set) begin
                rsv_err <= 1'b1;
            end
            if (bus.rdEnA) begin
                rd_data_a <= rd_data_a_nxt;
                rd_rdy_a  <= rd_rdy_a_nxt;
            end
            if (bus.rdEnB) begin
                rd_data_b <= rd_data_b_nxt;
                rd_rdy_b  <= rd_rdy_b_nxt;
            end
        end
    end

    assign bus.rdDataA  = rd_data_a;
    assign bus.rdRdyA   = rd_rdy_a;
    assign bus.rdDataB  = rd_data_b;
    assign bus.rdRdyB   = rd_rdy_b;
    assign bus.pendMask = pend;
    assign bus.rsvErr   = rsv_err;
endmodule

// File: tb/tb_reg_bank_mp.sv
// Bench for reg_bank_mp: instance 0 is 16-bit x 8 with a writable r0,
// instance 1 is 32-bit x 16 with r0 hardwired to zero.
module tb_reg_bank_mp;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    reg_bank_mp_if #(.WIDTH(16), .ID_W(3)) ifa ();
    reg_bank_mp_if #(.WIDTH(32), .ID_W(4)) ifb ();

    reg_bank_mp #(.WIDTH(16), .ID_W(3), .ZERO_R0(1'b0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    reg_bank_mp #(.WIDTH(32), .ID_W(4), .ZERO_R0(1'b1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    // Stimulus per instance
    logic        s_we  [2];
    logic [3:0]  s_wid [2];
    logic [31:0] s_wd  [2];
    logic        s_re  [2];
    logic [3:0]  s_rid [2];
    logic        s_rea [2];
    logic [3:0]  s_ida [2];
    logic        s_reb [2];
    logic [3:0]  s_idb [2];

    assign ifa.wrEn   = s_we[0];
    assign ifa.wrId   = s_wid[0][2:0];
    assign ifa.wrData = s_wd[0][15:0];
    assign ifa.rsvEn  = s_re[0];
    assign ifa.rsvId  = s_rid[0][2:0];
    assign ifa.rdEnA  = s_rea[0];
    assign ifa.rdIdA  = s_ida[0][2:0];
    assign ifa.rdEnB  = s_reb[0];
    assign ifa.rdIdB  = s_idb[0][2:0];

    assign ifb.wrEn   = s_we[1];
    assign ifb.wrId   = s_wid[1];
    assign ifb.wrData = s_wd[1];
    assign ifb.rsvEn  = s_re[1];
    assign ifb.rsvId  = s_rid[1];
    assign ifb.rdEnA  = s_rea[1];
    assign ifb.rdIdA  = s_ida[1];
    assign ifb.rdEnB  = s_reb[1];
    assign ifb.rdIdB  = s_idb[1];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: register contents, pending flags, sticky error, port outputs
    logic [31:0] m_reg  [2][16];
    bit          m_pend [2][16];
    bit          m_err  [2];
    logic [31:0] m_da   [2];
    logic [31:0] m_db   [2];
    bit          m_ra   [2];
    bit          m_rb   [2];

    task automatic model_read(input int k, input bit z, input bit wok, input logic [31:0] wdm,
                              input bit pn [16], input logic [3:0] id,
                              output logic [31:0] d, output bit r);
        if (z && id == 4'd0) begin
            d = 32'h0;
            r = 1'b1;
        end else begin
            d = (wok && s_wid[k] == id) ? wdm : m_reg[k][id];
            r = !pn[id];
        end
    endtask

    task automatic model_step(input int k);
        bit          z;
        logic [31:0] dm;
        logic [31:0] wdm;
        bit          wok, rok;
        bit          pn [16];
        logic [31:0] d;
        bit          r;
        z   = (k == 1);
        dm  = (k == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        wdm = s_wd[k] & dm;
        wok = s_we[k] && !(z && s_wid[k] == 4'd0);
        rok = s_re[k] && !(z && s_rid[k] == 4'd0);
        for (int i = 0; i < 16; i++) pn[i] = m_pend[k][i];
        if (wok) pn[s_wid[k]] = 1'b0;
        if (rok) begin
            if (m_pend[k][s_rid[k]] && !(wok && s_wid[k] == s_rid[k])) m_err[k] = 1'b1;
            pn[s_rid[k]] = 1'b1;
        end
        if (s_rea[k]) begin
            model_read(k, z, wok, wdm, pn, s_ida[k], d, r);
            m_da[k] = d;
            m_ra[k] = r;
        end
        if (s_reb[k]) begin
            model_read(k, z, wok, wdm, pn, s_idb[k], d, r);
            m_db[k] = d;
            m_rb[k] = r;
        end
        if (wok) m_reg[k][s_wid[k]] = wdm;
        for (int i = 0; i < 16; i++) m_pend[k][i] = pn[i];
    endtask

    function automatic logic [31:0] model_mask(input int k);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 16; i++) m[i] = m_pend[k][i];
        return m;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 16; i++) begin
                    m_reg[k][i]  = 32'h0;
                    m_pend[k][i] = 1'b0;
                end
                m_err[k] = 1'b0;
                m_da[k]  = 32'h0;
                m_db[k]  = 32'h0;
                m_ra[k]  = 1'b1;
                m_rb[k]  = 1'b1;
            end
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    // Cycle compare of both instances against the model
    always @(negedge clk) begin
        if (!reset) begin
            chk("a_rdDataA",  {16'h0, ifa.rdDataA},  m_da[0]);
            chk("a_rdRdyA",   {31'h0, ifa.rdRdyA},   {31'h0, m_ra[0]});
            chk("a_rdDataB",  {16'h0, ifa.rdDataB},  m_db[0]);
            chk("a_rdRdyB",   {31'h0, ifa.rdRdyB},   {31'h0, m_rb[0]});
            chk("a_pendMask", {24'h0, ifa.pendMask}, model_mask(0));
            chk("a_rsvErr",   {31'h0, ifa.rsvErr},   {31'h0, m_err[0]});
            chk("b_rdDataA",  ifb.rdDataA,           m_da[1]);
            chk("b_rdRdyA",   {31'h0, ifb.rdRdyA},   {31'h0, m_ra[1]});
            chk("b_rdDataB",  ifb.rdDataB,           m_db[1]);
            chk("b_rdRdyB",   {31'h0, ifb.rdRdyB},   {31'h0, m_rb[1]});
            chk("b_pendMask", {16'h0, ifb.pendMask}, model_mask(1));
            chk("b_rsvErr",   {31'h0, ifb.rsvErr},   {31'h0, m_err[1]});
        end
    end

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            s_we[k]  = 1'b0; s_wid[k] = 4'd0; s_wd[k] = 32'h0;
            s_re[k]  = 1'b0; s_rid[k] = 4'd0;
            s_rea[k] = 1'b0; s_ida[k] = 4'd0;
            s_reb[k] = 1'b0; s_idb[k] = 4'd0;
        end
    endtask

    task automatic wr(input int k, input logic [3:0] id, input logic [31:0] d);
        s_we[k] = 1'b1; s_wid[k] = id; s_wd[k] = d;
    endtask

    task automatic rsv(input int k, input logic [3:0] id);
        s_re[k] = 1'b1; s_rid[k] = id;
    endtask

    task automatic rda(input int k, input logic [3:0] id);
        s_rea[k] = 1'b1; s_ida[k] = id;
    endtask

    task automatic rdb(input int k, input logic [3:0] id);
        s_reb[k] = 1'b1; s_idb[k] = id;
    endtask

    // One rising edge applies the current strobes; returns just after the next falling edge.
    task automatic cyc();
        @(negedge clk);
        #1;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle();
        cyc();
        cyc();
        reset = 1'b0;

        // 1: reset state, read every index on both ports
        chk("rst_a_rdy",  {31'h0, ifa.rdRdyA},   32'h1);
        chk("rst_a_pend", {24'h0, ifa.pendMask}, 32'h0);
        chk("rst_b_err",  {31'h0, ifb.rsvErr},   32'h0);
        for (int i = 0; i < 16; i++) begin
            rda(0, 4'(i % 8)); rdb(0, 4'((i + 3) % 8));
            rda(1, 4'(i));     rdb(1, 4'(15 - i));
            cyc();
            chk("t1_a_data", {16'h0, ifa.rdDataA}, 32'h0);
            chk("t1_b_rdyB", {31'h0, ifb.rdRdyB},  32'h1);
        end

        // 2: write with same-cycle read -> bypass
        wr(0, 4'd5, 32'hBEEF); rda(0, 4'd5);
        cyc();
        chk("t2_bypass", {16'h0, ifa.rdDataA}, 32'hBEEF);
        chk("t2_rdy",    {31'h0, ifa.rdRdyA},  32'h1);
        rdb(0, 4'd5); wr(0, 4'd1, 32'h1111);
        cyc();
        chk("t2_stored", {16'h0, ifa.rdDataB}, 32'hBEEF);

        // 3: reserve, read pending, release with bypass
        rsv(0, 4'd3);
        cyc();
        rdb(0, 4'd3);
        cyc();
        chk("t3_rdy0",   {31'h0, ifa.rdRdyB},   32'h0);
        chk("t3_pend",   {24'h0, ifa.pendMask}, 32'h08);
        wr(0, 4'd3, 32'h1234); rdb(0, 4'd3); rda(0, 4'd2);
        cyc();
        chk("t3_data",   {16'h0, ifa.rdDataB},  32'h1234);
        chk("t3_rdy1",   {31'h0, ifa.rdRdyB},   32'h1);
        chk("t3_clear",  {24'h0, ifa.pendMask}, 32'h0);
        rsv(0, 4'd4); rda(0, 4'd4);
        cyc();
        chk("t3_rsv_rd", {31'h0, ifa.rdRdyA},   32'h0);

        // 4: double reserve -> sticky error; write+reserve same index
        rsv(0, 4'd2);
        cyc();
        chk("t4_err0",   {31'h0, ifa.rsvErr},   32'h0);
        rsv(0, 4'd2);
        cyc();
        chk("t4_err1",   {31'h0, ifa.rsvErr},   32'h1);
        wr(0, 4'd6, 32'h6666); rsv(0, 4'd6);
        cyc();
        chk("t4_pend6",  {24'h0, ifa.pendMask}, 32'h54);
        chk("t4_sticky", {31'h0, ifa.rsvErr},   32'h1);
        rda(0, 4'd6); rdb(0, 4'd6);
        cyc();
        chk("t4_same_d", {16'h0, ifa.rdDataB},  32'h6666);
        chk("t4_same_r", {31'h0, ifa.rdRdyA},   32'h0);

        // 5: hardwired r0 and the 32-bit x 16 configuration
        wr(1, 4'd0, 32'hFFFF_FFFF); rsv(1, 4'd0); rda(1, 4'd0);
        cyc();
        chk("t5_r0_data", ifb.rdDataA,           32'h0);
        chk("t5_r0_rdy",  {31'h0, ifb.rdRdyA},   32'h1);
        chk("t5_r0_pend", {16'h0, ifb.pendMask}, 32'h0);
        rdb(1, 4'd0);
        cyc();
        chk("t5_r0_err",  {31'h0, ifb.rsvErr},   32'h0);
        wr(1, 4'd15, 32'hDEAD_BEEF); rda(1, 4'd15);
        cyc();
        chk("t5_r15_byp", ifb.rdDataA,           32'hDEAD_BEEF);
        rsv(1, 4'd15);
        cyc();
        rdb(1, 4'd15);
        cyc();
        chk("t5_r15_rdy", {31'h0, ifb.rdRdyB},   32'h0);
        chk("t5_r15_pnd", {16'h0, ifb.pendMask}, 32'h8000);
        wr(1, 4'd15, 32'h1234_5678); rdb(1, 4'd15);
        cyc();
        chk("t5_r15_dat", ifb.rdDataB,           32'h1234_5678);
        chk("t5_r15_clr", {16'h0, ifb.pendMask}, 32'h0);
        rsv(1, 4'd7);
        cyc();
        wr(1, 4'd7, 32'h7777_7777); rsv(1, 4'd7); rda(1, 4'd7);
        cyc();
        chk("t5_wr_rsv_err", {31'h0, ifb.rsvErr}, 32'h0);
        chk("t5_wr_rsv_rdy", {31'h0, ifb.rdRdyA}, 32'h0);

        // 6: async reset mid-stream
        wr(0, 4'd4, 32'hAAAA); rsv(0, 4'd1);
        cyc();
        rda(0, 4'd4);
        cyc();
        chk("t6_pre",    {16'h0, ifa.rdDataA}, 32'hAAAA);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_d",  {16'h0, ifa.rdDataA},  32'h0);
        chk("t6_rst_r",  {31'h0, ifa.rdRdyA},   32'h1);
        chk("t6_rst_p",  {24'h0, ifa.pendMask}, 32'h0);
        chk("t6_rst_e",  {31'h0, ifa.rsvErr},   32'h0);
        chk("t6_rst_bp", {16'h0, ifb.pendMask}, 32'h0);
        wr(0, 4'd1, 32'h5555); rsv(0, 4'd2); rda(0, 4'd1);
        cyc();
        chk("t6_hold",   {16'h0, ifa.rdDataA},  32'h0);
        reset = 1'b0;
        rda(0, 4'd1); rdb(0, 4'd4);
        cyc();
        chk("t6_post_d", {16'h0, ifa.rdDataA},  32'h0);
        chk("t6_post_r", {31'h0, ifa.rdRdyA},   32'h1);
        chk("t6_post_b", {16'h0, ifa.rdDataB},  32'h0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
